// File: rtl/hazard_unit.sv
// Pipeline interlock and forwarding controller for the 5-stage MIPS CPU.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit #(
  parameter int AW     = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic [AW-1:0]    id_dest,
  input  logic             id_pcsrc,
  input  logic             ext_stall,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_d,
  output logic [1:0]       fwd_b_d,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic          r_exValid, r_exRegWrite, r_exMemToReg, r_exUseRs, r_exUseRt;
  logic [AW-1:0] r_exDest, r_exRs, r_exRt;
  logic          r_memValid, r_memRegWrite, r_memMemToReg;
  logic [AW-1:0] r_memDest;
  logic          r_wbValid, r_wbRegWrite, r_wbMemToReg;
  logic [AW-1:0] r_wbDest;

  logic w_exA, w_exB, w_memA, w_memB, w_wbA, w_wbB;
  logic w_memEa, w_memEb, w_wbEa, w_wbEb;
  logic w_hazard, w_hazStall;

  // A producer hits a consumer only if it really writes a non-zero register the consumer reads.
  function automatic logic hit(input logic v, input logic rw, input logic [AW-1:0] d,
                               input logic [AW-1:0] r, input logic useFlag);
    return v & rw & (d == r) & (r != '0) & useFlag;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exValid  <= 1'b0;
      r_memValid <= 1'b0;
      r_wbValid  <= 1'b0;
    end else if (!ext_stall) begin
      r_exValid     <= ~flush_e;
      r_exRegWrite  <= id_regwrite;
      r_exMemToReg  <= id_memtoreg;
      r_exDest      <= id_dest;
      r_exRs        <= id_rs;
      r_exRt        <= id_rt;
      r_exUseRs     <= id_use_rs;
      r_exUseRt     <= id_use_rt;
      r_memValid    <= r_exValid;
      r_memRegWrite <= r_exRegWrite;
      r_memMemToReg <= r_exMemToReg;
      r_memDest     <= r_exDest;
      r_wbValid     <= r_memValid;
      r_wbRegWrite  <= r_memRegWrite;
      r_wbMemToReg  <= r_memMemToReg;
      r_wbDest      <= r_memDest;
    end
  end

  always_comb begin
    w_exA   = hit(r_exValid, r_exRegWrite, r_exDest, id_rs, id_use_rs);
    w_exB   = hit(r_exValid, r_exRegWrite, r_exDest, id_rt, id_use_rt);
    w_memA  = hit(r_memValid, r_memRegWrite, r_memDest, id_rs, id_use_rs);
    w_memB  = hit(r_memValid, r_memRegWrite, r_memDest, id_rt, id_use_rt);
    w_wbA   = hit(r_wbValid, r_wbRegWrite, r_wbDest, id_rs, id_use_rs);
    w_wbB   = hit(r_wbValid, r_wbRegWrite, r_wbDest, id_rt, id_use_rt);
    w_memEa = r_exValid & hit(r_memValid, r_memRegWrite, r_memDest, r_exRs, r_exUseRs);
    w_memEb = r_exValid & hit(r_memValid, r_memRegWrite, r_memDest, r_exRt, r_exUseRt);
    w_wbEa  = r_exValid & hit(r_wbValid, r_wbRegWrite, r_wbDest, r_exRs, r_exUseRs);
    w_wbEb  = r_exValid & hit(r_wbValid, r_wbRegWrite, r_wbDest, r_exRt, r_exUseRt);
    if (FWD_EN)
      w_hazard = (r_exMemToReg & (w_exA | w_exB))
               | (id_branch & (w_exA | w_exB))
               | (id_branch & r_memMemToReg & (w_memA | w_memB));
    else
      w_hazard = w_exA | w_exB | w_memA | w_memB | w_wbA | w_wbB;
    w_hazStall = w_hazard & ~ext_stall & ~reset;
  end

  // Priority: reset, then external freeze, then hazard stall, then taken-branch flush.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      if (ext_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
      end else if (w_hazard) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        flush_d = id_pcsrc;
      end
      if (FWD_EN) begin
        fwd_a_d = (w_memA & ~r_memMemToReg) ? 2'b01 : (w_wbA ? 2'b10 : 2'b00);
        fwd_b_d = (w_memB & ~r_memMemToReg) ? 2'b01 : (w_wbB ? 2'b10 : 2'b00);
        fwd_a_e = (w_memEa & ~r_memMemToReg) ? 2'b10 : (w_wbEa ? 2'b01 : 2'b00);
        fwd_b_e = (w_memEb & ~r_memMemToReg) ? 2'b10 : (w_wbEb ? 2'b01 : 2'b00);
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stallCnt, r_flushCnt;

  // Saturating counters; an external freeze never counts as a hazard stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_hazStall && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (flush_d && (r_flushCnt != '1)) r_flushCnt <= r_flushCnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;
`else
  logic w_unusedStall;
  assign w_unusedStall = w_hazStall;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one full-forwarding instance and one
// interlock-only instance with narrow counters, sharing the same ID stimulus.
module tb_hazard_unit;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk, reset;
  logic [4:0] idRs, idRt, idDest;
  logic       idUseRs, idUseRt, idBranch, idRegWrite, idMemToReg, idPcSrc, extStall;

  logic        aStallF, aStallD, aFlushD, aFlushE;
  logic [1:0]  aFwdAD, aFwdBD, aFwdAE, aFwdBE;
  logic [15:0] aStallCnt, aFlushCnt;
  logic        bStallF, bStallD, bFlushD, bFlushE;
  logic [1:0]  bFwdAD, bFwdBD, bFwdAE, bFwdBE;
  logic [3:0]  bStallCnt, bFlushCnt;

  int vecCount = 0;
  int missCount = 0;

  hazard_unit #(.AW(5), .FWD_EN(1'b1), .CNT_W(16)) uFwd (
    .clk(clk), .reset(reset), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .id_branch(idBranch),
    .id_regwrite(idRegWrite), .id_memtoreg(idMemToReg), .id_dest(idDest),
    .id_pcsrc(idPcSrc), .ext_stall(extStall),
    .stall_f(aStallF), .stall_d(aStallD), .flush_d(aFlushD), .flush_e(aFlushE),
    .fwd_a_d(aFwdAD), .fwd_b_d(aFwdBD), .fwd_a_e(aFwdAE), .fwd_b_e(aFwdBE),
    .stall_cnt(aStallCnt), .flush_cnt(aFlushCnt)
  );

  hazard_unit #(.AW(5), .FWD_EN(1'b0), .CNT_W(4)) uNoFwd (
    .clk(clk), .reset(reset), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .id_branch(idBranch),
    .id_regwrite(idRegWrite), .id_memtoreg(idMemToReg), .id_dest(idDest),
    .id_pcsrc(idPcSrc), .ext_stall(extStall),
    .stall_f(bStallF), .stall_d(bStallD), .flush_d(bFlushD), .flush_e(bFlushE),
    .fwd_a_d(bFwdAD), .fwd_b_d(bFwdBD), .fwd_a_e(bFwdAE), .fwd_b_e(bFwdBE),
    .stall_cnt(bStallCnt), .flush_cnt(bFlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input int rs, input int rt, input int uRs, input int uRt,
                               input int br, input int rw, input int mtr, input int dest,
                               input int pc, input int ext);
    idRs       = 5'(rs);
    idRt       = 5'(rt);
    idUseRs    = (uRs != 0);
    idUseRt    = (uRt != 0);
    idBranch   = (br != 0);
    idRegWrite = (rw != 0);
    idMemToReg = (mtr != 0);
    idDest     = 5'(dest);
    idPcSrc    = (pc != 0);
    extStall   = (ext != 0);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    repeat (3) begin
      nop();
      advance();
    end
  endtask

  initial begin
    reset = 1'b1;
    nop();
    advance();
    advance();
    applyStimulus(9, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    checkOutput("rst.stallF", 32'(aStallF), 0);
    checkOutput("rst.stallD", 32'(aStallD), 0);
    checkOutput("rst.flushD", 32'(aFlushD), 1);
    checkOutput("rst.flushE", 32'(aFlushE), 1);
    checkOutput("rst.fwdAE", 32'(aFwdAE), 0);
    checkOutput("rst.stallCnt", 32'(aStallCnt), 0);
    checkOutput("rst.bFlushE", 32'(bFlushE), 1);
    reset = 1'b0;
    nop();
    advance();

    // add $8,$9,$10 ; sub $11,$8,$9
    applyStimulus(9, 10, 1, 1, 0, 1, 0, 8, 0, 0);
    checkOutput("add.stallF", 32'(aStallF), 0);
    advance();
    applyStimulus(8, 9, 1, 1, 0, 1, 0, 11, 0, 0);
    checkOutput("sub.stallF", 32'(aStallF), 0);
    checkOutput("sub.bStallF", 32'(bStallF), 1);
    advance();
    nop();
    checkOutput("sub.fwdAE.mem", 32'(aFwdAE), 2);
    checkOutput("sub.fwdBE", 32'(aFwdBE), 0);
    advance();
    nop();
    checkOutput("sub.fwdAE.clear", 32'(aFwdAE), 0);
    advance();
    applyStimulus(9, 10, 1, 1, 0, 1, 0, 8, 0, 0);
    advance();
    nop();
    advance();
    applyStimulus(8, 9, 1, 1, 0, 1, 0, 11, 0, 0);
    checkOutput("gap.stallF", 32'(aStallF), 0);
    checkOutput("gap.fwdAD", 32'(aFwdAD), 1);
    advance();
    nop();
    checkOutput("gap.fwdAE.wb", 32'(aFwdAE), 1);
    advance();

    // lw $8,0($0) ; add $9,$8,$8
    drain();
    applyStimulus(0, 8, 1, 0, 0, 1, 1, 8, 0, 0);
    checkOutput("lw.stallF", 32'(aStallF), 0);
    advance();
    applyStimulus(8, 8, 1, 1, 0, 1, 0, 9, 0, 0);
    checkOutput("ldu.stallF", 32'(aStallF), 1);
    checkOutput("ldu.stallD", 32'(aStallD), 1);
    checkOutput("ldu.flushE", 32'(aFlushE), 1);
    checkOutput("ldu.flushD", 32'(aFlushD), 0);
    advance();
    applyStimulus(8, 8, 1, 1, 0, 1, 0, 9, 0, 0);
    checkOutput("ldu.release", 32'(aStallF), 0);
    advance();
    nop();
    checkOutput("ldu.fwdAE", 32'(aFwdAE), 1);
    checkOutput("ldu.fwdBE", 32'(aFwdBE), 1);
    checkOutput("ldu.stallCnt", 32'(aStallCnt), PERF ? 32'd1 : 32'd0);
    advance();

    // lw $9,4($0) ; beq $9,$0 taken
    drain();
    applyStimulus(0, 9, 1, 0, 0, 1, 1, 9, 0, 0);
    advance();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(9, 0, 1, 1, 1, 0, 0, 0, 1, 0);
      checkOutput("brLd.stallF", 32'(aStallF), 1);
      checkOutput("brLd.flushD", 32'(aFlushD), 0);
      checkOutput("brLd.flushE", 32'(aFlushE), 1);
      advance();
    end
    applyStimulus(9, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    checkOutput("brLd.release", 32'(aStallF), 0);
    checkOutput("brLd.fwdAD", 32'(aFwdAD), 2);
    checkOutput("brLd.fwdBD", 32'(aFwdBD), 0);
    checkOutput("brLd.flushD.taken", 32'(aFlushD), 1);
    advance();
    nop();
    checkOutput("brLd.stallCnt", 32'(aStallCnt), PERF ? 32'd3 : 32'd0);
    checkOutput("brLd.flushCnt", 32'(aFlushCnt), PERF ? 32'd1 : 32'd0);
    advance();

    // add $9,$10,$11 ; beq $9,$0 taken
    drain();
    applyStimulus(10, 11, 1, 1, 0, 1, 0, 9, 0, 0);
    advance();
    applyStimulus(9, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    checkOutput("brAlu.stallF", 32'(aStallF), 1);
    checkOutput("brAlu.flushD", 32'(aFlushD), 0);
    advance();
    applyStimulus(9, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    checkOutput("brAlu.release", 32'(aStallF), 0);
    checkOutput("brAlu.fwdAD", 32'(aFwdAD), 1);
    checkOutput("brAlu.flushD", 32'(aFlushD), 1);
    advance();
    nop();
    checkOutput("brAlu.stallCnt", 32'(aStallCnt), PERF ? 32'd4 : 32'd0);
    checkOutput("brAlu.flushCnt", 32'(aFlushCnt), PERF ? 32'd2 : 32'd0);
    advance();

    // addi $0,$0,5 ; add $8,$0,$0
    drain();
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    advance();
    applyStimulus(0, 0, 1, 1, 0, 1, 0, 8, 0, 0);
    checkOutput("zero.stallF", 32'(aStallF), 0);
    checkOutput("zero.bStallF", 32'(bStallF), 0);
    checkOutput("zero.fwdAD", 32'(aFwdAD), 0);
    advance();
    nop();
    checkOutput("zero.fwdAE", 32'(aFwdAE), 0);
    advance();

    // load-use with a 4-cycle external freeze on top
    drain();
    applyStimulus(0, 8, 1, 0, 0, 1, 1, 8, 0, 0);
    advance();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8, 8, 1, 1, 0, 1, 0, 9, 0, 1);
      checkOutput("ext.stallF", 32'(aStallF), 1);
      checkOutput("ext.flushE", 32'(aFlushE), 0);
      checkOutput("ext.flushD", 32'(aFlushD), 0);
      advance();
    end
    applyStimulus(8, 8, 1, 1, 0, 1, 0, 9, 0, 0);
    checkOutput("ext.cntHeld", 32'(aStallCnt), PERF ? 32'd4 : 32'd0);
    checkOutput("ext.hazStall", 32'(aStallF), 1);
    checkOutput("ext.hazFlushE", 32'(aFlushE), 1);
    advance();
    applyStimulus(8, 8, 1, 1, 0, 1, 0, 9, 0, 0);
    checkOutput("ext.release", 32'(aStallF), 0);
    advance();
    nop();
    checkOutput("ext.fwdAE", 32'(aFwdAE), 1);
    checkOutput("ext.stallCnt", 32'(aStallCnt), PERF ? 32'd5 : 32'd0);
    advance();

    // interlock-only: back-to-back dependency stalls 3 cycles
    drain();
    applyStimulus(9, 10, 1, 1, 0, 1, 0, 8, 0, 0);
    advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8, 8, 1, 1, 0, 1, 0, 10, 0, 0);
      checkOutput("nf.stallF", 32'(bStallF), 1);
      checkOutput("nf.fwdAE", 32'(bFwdAE), 0);
      advance();
    end
    applyStimulus(8, 8, 1, 1, 0, 1, 0, 10, 0, 0);
    checkOutput("nf.release", 32'(bStallF), 0);
    checkOutput("nf.fwdAD", 32'(bFwdAD), 0);
    advance();

    // interlock-only: one independent instruction between stalls 2 cycles
    drain();
    applyStimulus(9, 10, 1, 1, 0, 1, 0, 8, 0, 0);
    advance();
    nop();
    advance();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(8, 8, 1, 1, 0, 1, 0, 10, 0, 0);
      checkOutput("nf1.stallF", 32'(bStallF), 1);
      advance();
    end
    applyStimulus(8, 8, 1, 1, 0, 1, 0, 10, 0, 0);
    checkOutput("nf1.release", 32'(bStallF), 0);
    advance();

    // reset in the second branch-after-load stall cycle
    drain();
    applyStimulus(0, 9, 1, 0, 0, 1, 1, 9, 0, 0);
    advance();
    applyStimulus(9, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    checkOutput("rbr.stallF", 32'(aStallF), 1);
    advance();
    reset = 1'b1;
    applyStimulus(9, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    checkOutput("rbr.rst.stallF", 32'(aStallF), 0);
    checkOutput("rbr.rst.stallD", 32'(aStallD), 0);
    checkOutput("rbr.rst.flushD", 32'(aFlushD), 1);
    checkOutput("rbr.rst.flushE", 32'(aFlushE), 1);
    checkOutput("rbr.rst.fwdAD", 32'(aFwdAD), 0);
    advance();
    reset = 1'b0;
    applyStimulus(9, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    checkOutput("rbr.post.stallF", 32'(aStallF), 0);
    checkOutput("rbr.post.flushD", 32'(aFlushD), 1);
    checkOutput("rbr.post.fwdAD", 32'(aFwdAD), 0);
    checkOutput("rbr.post.stallCnt", 32'(aStallCnt), 0);
    checkOutput("rbr.post.flushCnt", 32'(aFlushCnt), 0);
    checkOutput("rbr.post.bFlushCnt", 32'(bFlushCnt), 0);
    advance();

    // continuous taken-branch stream drives flush_cnt to saturation
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1, 1, 1, 0, 0, 0, 1, 0);
      advance();
    end
    nop();
    checkOutput("sat.bFlushCnt", 32'(bFlushCnt), PERF ? 32'd15 : 32'd0);
    checkOutput("sat.aFlushCnt", 32'(aFlushCnt), PERF ? 32'd21 : 32'd0);
    checkOutput("sat.aStallCnt", 32'(aStallCnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
